serial_subtractor: RTL and testbench

- Parametrised, bit-serial, multi-cycle unsigned subtractor: DIFF = A - B - BIN over WIDTH bits.
- Processes one bit per clock, LSB first, using a single registered full-subtractor cell with the borrow held in a flip-flop.
- Successor to the single-bit combinational subtractor cell: adds width, a borrow-in, a start/done handshake and held results.
- Used where area matters more than latency.

---
 rtl/serial_subtractor.sv | 193 +++++++++++++++++++
 tb/tb_serial_subtractor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor computing DIFF = A - B - BIN over WIDTH bits.
// One full-subtractor cell is time-shared across all bit positions. It handles
// one bit per clock, LSB first, and keeps the borrow in a flip-flop between
// bits. The latency from the accepting START edge to DONE is WIDTH+1 clocks.
// The block can accept a new operation every WIDTH+2 clocks.
//
// Optional feature:
//   SERIAL_SUB_SAT_EN  - when defined, a result that underflows is clamped to 0.
//                        BOUT still reports the borrow.
//
// Parameters:
//   WIDTH  operand/result width in bits (1..64)
//
// Ports:
//   CLK    in   rising-edge clock
//   RST    in   synchronous active-high reset
//   START  in   operation request; sampled only while BUSY=0
//   A      in   minuend, captured on an accepted START
//   B      in   subtrahend, captured on an accepted START
//   BIN    in   borrow-in, captured on an accepted START
//   BUSY   out  high while an operation is in progress
//   DONE   out  one-cycle pulse when a new result is written
//   DIFF   out  difference, held between completions
//   BOUT   out  final borrow-out (A < B+BIN), held
//   ZERO   out  DIFF==0, held

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             ZERO
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // State and datapath registers
  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_sa_nxt;
  logic [WIDTH-1:0] w_sb_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_br_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_bout_nxt;
  logic             w_zero_nxt;

  // Full-subtractor cell for the current bit
  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_borrow;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_res_shift;

  assign w_a      = r_sa[0];
  assign w_b      = r_sb[0];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_borrow = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

  // Set on the edge that processes the MSB
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  // Shift the new difference bit into the result MSB. Using shifts instead
  // of slices keeps WIDTH=1 legal.
  assign w_res_shift = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_sa_nxt    = r_sa;
    w_sb_nxt    = r_sb;
    w_res_nxt   = r_res;
    w_br_nxt    = r_br;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_diff_nxt  = r_diff;
    w_bout_nxt  = r_bout;
    w_zero_nxt  = r_zero;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_sa_nxt    = A;
          w_sb_nxt    = B;
          w_br_nxt    = BIN;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        w_sa_nxt  = r_sa >> 1;
        w_sb_nxt  = r_sb >> 1;
        w_br_nxt  = w_borrow;
        w_res_nxt = w_res_shift;
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last_bit) begin
          w_state_nxt = S_FIN;
        end
      end

      S_FIN: begin
        w_diff_nxt  = r_res;
        w_bout_nxt  = r_br;
        w_zero_nxt  = (r_res == '0);
`ifdef SERIAL_SUB_SAT_EN
        // An underflow clamps the result to zero. BOUT still flags the clamp.
        if (r_br) begin
          w_diff_nxt = '0;
          w_zero_nxt = 1'b1;
        end
`endif
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything, including a run
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sa    <= w_sa_nxt;
      r_sb    <= w_sb_nxt;
      r_res   <= w_res_nxt;
      r_br    <= w_br_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_diff  <= w_diff_nxt;
      r_bout  <= w_bout_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign DIFF = r_diff;
  assign BOUT = r_bout;
  assign ZERO = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: a WIDTH=8 instance and a WIDTH=1 instance.
// Expected results come from plain integer arithmetic on the operands.

module tb_serial_subtractor;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8, zero8;
  logic [7:0] a8, b8, diff8;
  logic       start1, bin1, busy1, done1, bout1, zero1;
  logic [0:0] a1, b1, diff1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] prev_diff;
  logic       prev_bout, prev_zero;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8), .BIN(bin8),
    .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BOUT(bout8), .ZERO(zero8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .BIN(bin1),
    .BUSY(busy1), .DONE(done1), .DIFF(diff1), .BOUT(bout1), .ZERO(zero1)
  );

  // Reference: integer subtraction, borrow when the result is negative
  function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                  output int d, output logic bo, output logic z);
    int raw;
    raw = a - b - bin;
    bo  = (raw < 0);
    d   = raw & ((1 << w) - 1);
`ifdef SERIAL_SUB_SAT_EN
    if (bo) d = 0;
`endif
    z = (d == 0);
  endfunction

  // One operation on the 8-bit DUT. When inj_n >= 0, a START carrying
  // different operands is pulsed while the DUT is busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input int inj_n, input string tag);
    int   ed, n;
    logic eb, ez;
    ref_sub(W, int'(a), int'(b), int'(bin), ed, eb, ez);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      vectors++;
      if (busy8 !== 1'b1) begin
        miscompares++;
        $display("FAIL %s busy n=%0d: got %b want 1", tag, n, busy8);
      end
      vectors++;
      if (diff8 !== prev_diff || bout8 !== prev_bout || zero8 !== prev_zero) begin
        miscompares++;
        $display("FAIL %s held n=%0d: got %h/%b/%b want %h/%b/%b", tag, n,
                 diff8, bout8, zero8, prev_diff, prev_bout, prev_zero);
      end
      if (n == inj_n) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    vectors++;
    if (n != W + 1) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", tag, n, W + 1);
    end
    vectors++;
    if (diff8 !== 8'(ed) || bout8 !== eb || zero8 !== ez || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s result: got diff=%h bout=%b zero=%b busy=%b want %h/%b/%b/0",
               tag, diff8, bout8, zero8, busy8, 8'(ed), eb, ez);
    end
    @(negedge clk);
    vectors++;
    if (done8 !== 1'b0 || diff8 !== 8'(ed)) begin
      miscompares++;
      $display("FAIL %s done_pulse: got done=%b diff=%h want 0/%h", tag, done8, diff8, 8'(ed));
    end
    prev_diff = 8'(ed); prev_bout = eb; prev_zero = ez;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h01;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    vectors++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || zero8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b zero=%b want all 0",
               busy8, done8, diff8, bout8, zero8);
    end
    vectors++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || bout1 !== 1'b0 || zero1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset1: got busy=%b done=%b diff=%b bout=%b zero=%b want all 0",
               busy1, done1, diff1, bout1, zero1);
    end
    prev_diff = 8'h00; prev_bout = 1'b0; prev_zero = 1'b0;
  endtask

  task automatic test_basic();
    run_op(8'h5A, 8'h3C, 1'b0, -1, "basic");
    vectors++;
    if (prev_diff !== 8'h1E || diff8 !== 8'h1E) begin
      miscompares++;
      $display("FAIL basic_const: got %h want 1e", diff8);
    end
  endtask

  task automatic test_wrap();
    run_op(8'h00, 8'h01, 1'b0, -1, "wrap");
    run_op(8'h10, 8'h0F, 1'b1, -1, "equal_borrow");
    run_op(8'h03, 8'h07, 1'b0, -1, "underflow");
  endtask

  task automatic test_busy();
    run_op(8'h80, 8'h01, 1'b0, 2, "busy_protect");
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      vectors++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_extra i=%0d: got done=%b busy=%b want 0/0", i, done8, busy8);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || zero8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b zero=%b want all 0",
               busy8, done8, diff8, bout8, zero8);
    end
    prev_diff = 8'h00; prev_bout = 1'b0; prev_zero = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      vectors++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_idle i=%0d: got done=%b busy=%b want 0/0", i, done8, busy8);
      end
    end
    run_op(8'h44, 8'h11, 1'b0, -1, "post_reset");
  endtask

  task automatic test_back_to_back();
    int   ed1, ed2, n, d1, d2;
    logic eb1, ez1, eb2, ez2;
    ref_sub(W, 5, 3, 0, ed1, eb1, ez1);
    ref_sub(W, 3, 5, 0, ed2, eb2, ez2);
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h05;
    n = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && n < 60) begin
      if (done8 === 1'b1) begin
        if (d1 < 0) begin
          d1 = n;
          vectors++;
          if (diff8 !== 8'(ed1) || bout8 !== eb1) begin
            miscompares++;
            $display("FAIL b2b_first: got %h/%b want %h/%b", diff8, bout8, 8'(ed1), eb1);
          end
        end else begin
          d2 = n;
          vectors++;
          if (diff8 !== 8'(ed2) || bout8 !== eb2 || zero8 !== ez2) begin
            miscompares++;
            $display("FAIL b2b_second: got %h/%b/%b want %h/%b/%b",
                     diff8, bout8, zero8, 8'(ed2), eb2, ez2);
          end
        end
      end
      if (n == W + 2) begin
        start8 = 1'b0;
        vectors++;
        if (busy8 !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart: got busy=%b want 1", busy8);
        end
      end
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    vectors++;
    if (d1 != W + 1 || d2 - d1 != W + 2) begin
      miscompares++;
      $display("FAIL b2b_spacing: got first=%0d gap=%0d want %0d/%0d", d1, d2 - d1, W + 1, W + 2);
    end
    @(negedge clk);
    prev_diff = 8'(ed2); prev_bout = eb2; prev_zero = ez2;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1, "random");
    end
  endtask

  task automatic test_width1();
    int   ed, n;
    logic eb, ez, av, bv, cv;
    for (int i = 0; i < 8; i++) begin
      av = i[2]; bv = i[1]; cv = i[0];
      ref_sub(1, int'(av), int'(bv), int'(cv), ed, eb, ez);
      @(negedge clk);
      a1 = av; b1 = bv; bin1 = cv; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (n != 2) begin
        miscompares++;
        $display("FAIL w1_latency abc=%b%b%b: got %0d want 2", av, bv, cv, n);
      end
      vectors++;
      if (diff1 !== 1'(ed) || bout1 !== eb || zero1 !== ez) begin
        miscompares++;
        $display("FAIL w1_result abc=%b%b%b: got %b/%b/%b want %b/%b/%b",
                 av, bv, cv, diff1, bout1, zero1, 1'(ed), eb, ez);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    prev_diff = 8'h00; prev_bout = 1'b0; prev_zero = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
